// File: rtl/calc_pkg.sv
// Shared calculator constants: display digit codes, magnitude limit and
// converter FSM states. Also used by bcdtobin and the keypad entry block.
package calc_pkg;

  localparam int unsigned DIG_W = 4;

  localparam logic [DIG_W-1:0] DIG_BLANK = 4'hA;
  localparam logic [DIG_W-1:0] DIG_MINUS = 4'hB;
  localparam logic [DIG_W-1:0] DIG_ERR   = 4'hE;

  localparam int unsigned MAX_MAG = 999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_e;

endpackage

// File: rtl/dabble_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   dig_i  BCD digit before correction
//   dig_c  corrected digit (combinational)
module dabble_adj
  import calc_pkg::*;
(
  input  logic [DIG_W-1:0] dig_i,
  output logic [DIG_W-1:0] dig_c
);

  assign dig_c = (dig_i >= DIG_W'(5)) ? dig_i + DIG_W'(3) : dig_i;

endmodule

// File: rtl/bintobcd_seq.sv
// Sequential signed binary to display-BCD converter (one bit per clock,
// double-dabble). BCD3 is the fixed sign position, BCD2..BCD0 the magnitude.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   binin          signed value, sampled only on an accepted start
//   start          conversion request, accepted only while idle
//   busy           high from the accept edge until the done cycle
//   done           one-cycle pulse when BCD3..BCD0 are updated
//   BCD0..BCD3     display codes: 0-9 digit, A blank, B minus, E error
module bintobcd_seq
  import calc_pkg::*;
#(
  parameter int unsigned BITS   = 11,
  parameter int unsigned BCDDIG = 4,
  parameter int unsigned LZB    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] binin,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [3:0]      BCD0,
  output logic [3:0]      BCD1,
  output logic [3:0]      BCD2,
  output logic [3:0]      BCD3
);

  localparam int unsigned CNT_W = $clog2(BITS);
  localparam int unsigned SCR_W = DIG_W * BCDDIG;
  localparam int unsigned SH_W  = SCR_W + BITS;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BITS-1:0]    mag_q, mag_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d, scratch_adj;
  logic [SH_W-1:0]    shift_w;
  logic               neg_q, ovf_q;
  logic [BITS-1:0]    abs_c;
  logic [DIG_W-1:0]   hund_c, tens_c, units_c;
  logic [DIG_W-1:0]   fmt0_c, fmt1_c, fmt2_c, fmt3_c;

  // Magnitude in BITS unsigned bits; the most negative input maps to 2^(BITS-1).
  assign abs_c = binin[BITS-1] ? (~binin + BITS'(1)) : binin;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar g = 0; g < BCDDIG; g++) begin : g_adj
    dabble_adj u_adj (
      .dig_i (scratch_q[g*DIG_W +: DIG_W]),
      .dig_c (scratch_adj[g*DIG_W +: DIG_W])
    );
  end

  // One double-dabble step: shift corrected scratch and magnitude left as one word.
  assign shift_w              = {scratch_adj, mag_q} << 1;
  assign {scratch_d, mag_d}   = shift_w;

  assign units_c = scratch_q[0*DIG_W +: DIG_W];
  assign tens_c  = scratch_q[1*DIG_W +: DIG_W];
  assign hund_c  = scratch_q[2*DIG_W +: DIG_W];

  // Display formatting: error fill, fixed sign slot, optional leading-zero blanking.
  always_comb begin
    fmt3_c = DIG_ERR;
    fmt2_c = DIG_ERR;
    fmt1_c = DIG_ERR;
    fmt0_c = DIG_ERR;
    if (!ovf_q) begin
      fmt0_c = units_c;
      fmt1_c = ((LZB != 0) && (hund_c == '0) && (tens_c == '0)) ? DIG_BLANK : tens_c;
      fmt2_c = ((LZB != 0) && (hund_c == '0)) ? DIG_BLANK : hund_c;
      fmt3_c = neg_q ? DIG_MINUS : DIG_BLANK;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mag_q     <= '0;
      scratch_q <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      BCD3      <= DIG_BLANK;
      BCD2      <= DIG_BLANK;
      BCD1      <= DIG_BLANK;
      BCD0      <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SHIFT;
            neg_q     <= binin[BITS-1];
            mag_q     <= abs_c;
            ovf_q     <= (abs_c > BITS'(MAX_MAG));
            cnt_q     <= CNT_W'(BITS - 1);
            scratch_q <= '0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_d;
          if (cnt_q == '0) begin
            state_q <= FORMAT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FORMAT: begin
          BCD3    <= fmt3_c;
          BCD2    <= fmt2_c;
          BCD1    <= fmt1_c;
          BCD0    <= fmt0_c;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bintobcd_seq.sv
// Scoreboard bench for bintobcd_seq: two instances (LZB=1 and LZB=0) share the
// stimulus; expected displays come from a decimal arithmetic model.
module tb_bintobcd_seq;

  localparam int BITS = 11;
  localparam int LAT  = BITS + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [BITS-1:0] binin;
  logic            busy_a, done_a, busy_b, done_b;
  logic [3:0]      a0, a1, a2, a3, b0, b1, b2, b3;

  always #5 clk = ~clk;

  bintobcd_seq #(.BITS(BITS), .BCDDIG(4), .LZB(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .binin(binin), .start(start),
    .busy(busy_a), .done(done_a),
    .BCD0(a0), .BCD1(a1), .BCD2(a2), .BCD3(a3)
  );

  bintobcd_seq #(.BITS(BITS), .BCDDIG(4), .LZB(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .binin(binin), .start(start),
    .busy(busy_b), .done(done_b),
    .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3)
  );

  typedef struct {
    logic [15:0] e1;
    logic [15:0] e0;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        it;
  int          edge_cnt    = 0;
  int          acc_last    = -1000;
  int          free_at     = 0;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] last1, last0;
  bit          be, de;

  // Decimal reference: {sign, hundreds, tens, units} display codes.
  function automatic logic [15:0] model(input int v, input bit lzb);
    int m, h, t, u;
    logic [3:0] d3, d2, d1, d0;
    m = (v < 0) ? -v : v;
    if (m > 999) return 16'hEEEE;
    h  = m / 100;
    t  = (m / 10) % 10;
    u  = m % 10;
    d3 = (v < 0) ? 4'hB : 4'hA;
    d2 = (lzb && h == 0) ? 4'hA : 4'(h);
    d1 = (lzb && h == 0 && t == 0) ? 4'hA : 4'(t);
    d0 = 4'(u);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  task automatic chk_reset();
    check16("reset_bcd_lzb1", {a3, a2, a1, a0}, 16'hAAA0);
    check16("reset_bcd_lzb0", {b3, b2, b1, b0}, 16'hAAA0);
    check1("reset_busy", busy_a, 1'b0);
    check1("reset_done", done_a, 1'b0);
  endtask

  // Drive one cycle; pushes the expected result when the converter will accept.
  task automatic drive(input bit s, input int v, output bit acc);
    @(negedge clk);
    start = s;
    binin = BITS'(v);
    acc   = 1'b0;
    if (s && (edge_cnt + 1 >= free_at)) begin
      exp_q.push_back('{model(v, 1'b1), model(v, 1'b0), edge_cnt + 1});
      acc_last = edge_cnt + 1;
      free_at  = edge_cnt + 1 + LAT + 1;
      acc      = 1'b1;
    end
  endtask

  task automatic drain();
    bit d;
    for (int i = 0; i < 4 * LAT && exp_q.size() != 0; i++) drive(1'b0, 0, d);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // Monitor: timing of busy/done, pop-and-compare on done, hold between results.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      be = (edge_cnt >= acc_last) && (edge_cnt <= acc_last + BITS);
      de = (edge_cnt == acc_last + LAT);
      check1("busy", busy_a, be);
      check1("busy_lzb0", busy_b, be);
      check1("done", done_a, de);
      check1("done_lzb0", done_b, de);
      if (done_a === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_unexpected: got done=1 expected no pending result at edge %0d", edge_cnt);
        end else begin
          it = exp_q.pop_front();
          vectors++;
          if (edge_cnt != it.acc + LAT) begin
            miscompares++;
            $display("FAIL latency: got %0d expected %0d", edge_cnt - it.acc, LAT);
          end
          last1 = it.e1;
          last0 = it.e0;
        end
      end
      check16("bcd_lzb1", {a3, a2, a1, a0}, last1);
      check16("bcd_lzb0", {b3, b2, b1, b0}, last0);
    end
  end

  initial begin
    bit acc;
    int dir[14] = '{123, -45, -7, 0, 999, -999, 1000, -1024, 1023, -1000, 1, 10, 100, -100};
    int n, v, guard;

    rst_n = 1'b0;
    start = 1'b0;
    binin = '0;
    last1 = 16'hAAA0;
    last0 = 16'hAAA0;
    repeat (2) @(posedge clk);
    #1 chk_reset();
    @(negedge clk) rst_n = 1'b1;

    // Directed values including the error boundaries
    foreach (dir[i]) begin
      drive(1'b1, dir[i], acc);
      drain();
    end

    // Start while busy with a new value must be ignored
    drive(1'b1, 123, acc);
    repeat (3) drive(1'b0, 0, acc);
    drive(1'b1, -456, acc);
    drive(1'b0, 0, acc);
    drain();

    // Start held high: back-to-back conversions with binin changing every cycle
    for (int i = 0; i < 3 * (LAT + 1) + 2; i++)
      drive(1'b1, int'($urandom_range(2047)) - 1024, acc);
    drain();

    // Reset in the middle of SHIFT aborts the conversion
    drive(1'b1, -321, acc);
    repeat (4) drive(1'b0, 0, acc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    exp_q.delete();
    acc_last = -1000;
    free_at  = 0;
    last1    = 16'hAAA0;
    last0    = 16'hAAA0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * LAT) drive(1'b0, 0, acc);

    // Random start pattern and values over the full input range
    n = 0;
    guard = 0;
    while (n < 300 && guard < 300 * 40) begin
      drive($urandom_range(2) == 0, int'($urandom_range(2047)) - 1024, acc);
      if (acc) n++;
      guard++;
    end
    drain();

    // Sweep of every displayable value with start held high
    v = -999;
    guard = 0;
    while (v <= 999 && guard < 2000 * (LAT + 2)) begin
      drive(1'b1, v, acc);
      if (acc) v++;
      guard++;
    end
    drive(1'b0, 0, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
